of_ex_operand_latch: RTL and testbench

//  OF->EX pipeline register with operand forwarding, 5-stage SimpleRISC-style core.
//  - Consumes the RW->OF conflict flags from the src1/src2 forwarding units.
//  - Selects forwarded operands and builds the extended immediate.
//  - Detects load-use hazards and inserts bubbles. Honours EX hold and branch flush.

---
 rtl/pipe_pkg.sv | 86 ++++++++
 rtl/of_imm_ext.sv | 25 ++
 rtl/of_ex_operand_latch.sv | 111 +++++++++++
 tb/tb_of_ex_operand_latch.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, field positions, source-usage decode.
// Used by the OF->EX latch and by the src1/src2 forwarding units.
package pipe_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_MOD  = 5'b00100;
    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_OR   = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_MOV  = 5'b01001;
    localparam logic [4:0] OP_LSL  = 5'b01010;
    localparam logic [4:0] OP_LSR  = 5'b01011;
    localparam logic [4:0] OP_ASR  = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b01101;
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;

    localparam logic [31:0] NOP_IR = 32'h6800_0000;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int I_BIT  = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 22;
    localparam int RS1_HI = 21;
    localparam int RS1_LO = 18;
    localparam int RS2_HI = 17;
    localparam int RS2_LO = 14;
    localparam int MOD_HI = 17;
    localparam int MOD_LO = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam logic [3:0] RA_REG = 4'd15;

    function automatic logic [4:0] opcode(input logic [31:0] ir);
        return ir[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [3:0] rd_of(input logic [31:0] ir);
        return ir[RD_HI:RD_LO];
    endfunction

    function automatic logic uses_src1(input logic [31:0] ir);
        logic u;
        u = 1'b1;
        case (ir[OPC_HI:OPC_LO])
            OP_NOT, OP_MOV, OP_NOP,
            OP_BEQ, OP_BGT, OP_B, OP_CALL: u = 1'b0;
            default:                        u = 1'b1;
        endcase
        return u;
    endfunction

    // ret reads the return address register instead of rs1
    function automatic logic [3:0] src1_reg(input logic [31:0] ir);
        return (ir[OPC_HI:OPC_LO] == OP_RET) ? RA_REG : ir[RS1_HI:RS1_LO];
    endfunction

    // st always reads rd as store data; others read rs2 only in reg form
    function automatic logic uses_src2(input logic [31:0] ir);
        logic u;
        u = 1'b0;
        case (ir[OPC_HI:OPC_LO])
            OP_ST:                 u = 1'b1;
            OP_NOP, OP_B, OP_BEQ,
            OP_BGT, OP_CALL, OP_RET: u = 1'b0;
            default:               u = ~ir[I_BIT];
        endcase
        return u;
    endfunction

    function automatic logic [3:0] src2_reg(input logic [31:0] ir);
        return (ir[OPC_HI:OPC_LO] == OP_ST) ? ir[RD_HI:RD_LO] : ir[RS2_HI:RS2_LO];
    endfunction

endpackage

// File: rtl/of_imm_ext.sv
// Immediate extender: imm[17:0] = {mod, imm16} -> DATA_W operand.
// mod 00/11 sign-extend, 01 zero-extend, 10 shift into the upper half.
module of_imm_ext #(
    parameter int DATA_W = 32
) (
    input  logic [17:0]       imm,
    output logic [DATA_W-1:0] imm_ext
);
    logic [15:0] v;
    logic [31:0] hi;

    assign v  = imm[15:0];
    assign hi = {v, 16'h0000};

    // Select the extension mode from the modifier bits
    always_comb begin
        imm_ext = DATA_W'($signed(v));
        case (imm[17:16])
            2'b01:   imm_ext = DATA_W'(v);
            2'b10:   imm_ext = DATA_W'(hi);
            default: imm_ext = DATA_W'($signed(v));
        endcase
    end

endmodule

// File: rtl/of_ex_operand_latch.sv
// OF->EX pipeline register with RW forwarding, load-use bubbles, hold, flush.
// Optional perf counters are built when OF_EX_PERF_EN is defined.
module of_ex_operand_latch
    import pipe_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter logic [31:0] NOP_IR = pipe_pkg::NOP_IR
`ifdef OF_EX_PERF_EN
    ,
    parameter int          CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              of_valid,
    input  logic [31:0]       of_pc,
    input  logic [31:0]       of_ir,
    input  logic [DATA_W-1:0] of_rf_a,
    input  logic [DATA_W-1:0] of_rf_b,
    input  logic [DATA_W-1:0] rw_result,
    input  logic              is_RW_OF_conflict_src1,
    input  logic              is_RW_OF_conflict_src2,
    input  logic              branch_taken,
    input  logic              ex_hold,
    output logic              of_stall,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_ir,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_op2
`ifdef OF_EX_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_bubbles,
    output logic [CNT_W-1:0]  perf_fwd_src1,
    output logic [CNT_W-1:0]  perf_fwd_src2
`endif
);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] op2;
    logic              ex_is_ld;
    logic              hit1;
    logic              hit2;
    logic              lu;

    of_imm_ext #(
        .DATA_W (DATA_W)
    ) u_imm (
        .imm     (of_ir[17:0]),
        .imm_ext (imm_ext)
    );

    assign op_a = is_RW_OF_conflict_src1 ? rw_result : of_rf_a;
    assign op_b = is_RW_OF_conflict_src2 ? rw_result : of_rf_b;
    assign op2  = of_ir[I_BIT] ? imm_ext : op_b;

    assign ex_is_ld = ex_valid && (opcode(ex_ir) == OP_LD);
    assign hit1     = uses_src1(of_ir) && (src1_reg(of_ir) == rd_of(ex_ir));
    assign hit2     = uses_src2(of_ir) && (src2_reg(of_ir) == rd_of(ex_ir));
    assign lu       = ex_is_ld && of_valid && (hit1 || hit2);

    // A flush kills the stall: the OF instruction is discarded anyway
    assign of_stall = ~branch_taken & (ex_hold | lu);

    // EX register: reset > flush > hold > load-use bubble > normal load
    always_ff @(posedge clk) begin
        if (reset || branch_taken || (!ex_hold && lu)) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_ir    <= NOP_IR;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_op2   <= '0;
        end else if (!ex_hold) begin
            ex_valid <= of_valid;
            ex_pc    <= of_pc;
            ex_ir    <= of_ir;
            ex_a     <= op_a;
            ex_b     <= op_b;
            ex_op2   <= op2;
        end
    end

`ifdef OF_EX_PERF_EN
    logic bubble_ld;
    logic normal_ld;

    assign bubble_ld = branch_taken || (!ex_hold && lu);
    assign normal_ld = !branch_taken && !ex_hold && !lu;

    // Saturating event counters, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_bubbles  <= '0;
            perf_fwd_src1 <= '0;
            perf_fwd_src2 <= '0;
        end else begin
            if (bubble_ld && (perf_bubbles != '1))
                perf_bubbles <= perf_bubbles + 1'b1;
            if (normal_ld && is_RW_OF_conflict_src1 && (perf_fwd_src1 != '1))
                perf_fwd_src1 <= perf_fwd_src1 + 1'b1;
            if (normal_ld && is_RW_OF_conflict_src2 && (perf_fwd_src2 != '1))
                perf_fwd_src2 <= perf_fwd_src2 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_of_ex_operand_latch.sv
// Bench for of_ex_operand_latch: reference model feeds a scoreboard queue,
// directed scenarios followed by a constrained-random run.
module tb_of_ex_operand_latch;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] op2;
    } ex_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        of_valid;
    logic [31:0] of_pc;
    logic [31:0] of_ir;
    logic [31:0] of_rf_a;
    logic [31:0] of_rf_b;
    logic [31:0] rw_result;
    logic        c1;
    logic        c2;
    logic        bt;
    logic        hold;
    logic        of_stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_ir;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_op2;
`ifdef OF_EX_PERF_EN
    logic [31:0] perf_bubbles;
    logic [31:0] perf_fwd_src1;
    logic [31:0] perf_fwd_src2;
    int unsigned pb, pf1, pf2;
`endif

    int   total = 0;
    int   bad   = 0;
    ex_t  q[$];
    ex_t  mdl;

    always #5 clk = ~clk;

    of_ex_operand_latch dut (
        .clk                    (clk),
        .reset                  (reset),
        .of_valid               (of_valid),
        .of_pc                  (of_pc),
        .of_ir                  (of_ir),
        .of_rf_a                (of_rf_a),
        .of_rf_b                (of_rf_b),
        .rw_result              (rw_result),
        .is_RW_OF_conflict_src1 (c1),
        .is_RW_OF_conflict_src2 (c2),
        .branch_taken           (bt),
        .ex_hold                (hold),
        .of_stall               (of_stall),
        .ex_valid               (ex_valid),
        .ex_pc                  (ex_pc),
        .ex_ir                  (ex_ir),
        .ex_a                   (ex_a),
        .ex_b                   (ex_b),
        .ex_op2                 (ex_op2)
`ifdef OF_EX_PERF_EN
        ,
        .perf_bubbles           (perf_bubbles),
        .perf_fwd_src1          (perf_fwd_src1),
        .perf_fwd_src2          (perf_fwd_src2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins(input int op, input bit i, input int rd,
                                        input int rs1, input logic [17:0] lo);
        logic [4:0] o;
        logic [3:0] d;
        logic [3:0] s;
        o = 5'(op);
        d = 4'(rd);
        s = 4'(rs1);
        return {o, i, d, s, lo};
    endfunction

    function automatic logic [17:0] rs2f(input int r);
        logic [3:0] x;
        x = 4'(r);
        return {x, 14'd0};
    endfunction

    function automatic bit m_use1(input logic [31:0] ir);
        int op;
        op = int'(ir[31:27]);
        return !(op == 8 || op == 9 || op == 13 || (op >= 16 && op <= 19));
    endfunction

    function automatic logic [3:0] m_reg1(input logic [31:0] ir);
        if (ir[31:27] == 5'd20) return 4'hF;
        return ir[21:18];
    endfunction

    function automatic bit m_use2(input logic [31:0] ir);
        int op;
        op = int'(ir[31:27]);
        if (op == 15) return 1'b1;
        if (op == 13 || (op >= 16 && op <= 20)) return 1'b0;
        return !ir[26];
    endfunction

    function automatic logic [3:0] m_reg2(input logic [31:0] ir);
        if (ir[31:27] == 5'd15) return ir[25:22];
        return ir[17:14];
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] ir);
        logic [15:0] v;
        v = ir[15:0];
        case (ir[17:16])
            2'd1:    return {16'h0000, v};
            2'd2:    return {v, 16'h0000};
            default: return {{16{v[15]}}, v};
        endcase
    endfunction

    function automatic bit m_lu();
        logic [3:0] d;
        d = mdl.ir[25:22];
        if (!(mdl.v && mdl.ir[31:27] == 5'd14 && of_valid)) return 1'b0;
        return (m_use1(of_ir) && m_reg1(of_ir) == d) ||
               (m_use2(of_ir) && m_reg2(of_ir) == d);
    endfunction

    task automatic setof(input bit v, input logic [31:0] pc, input logic [31:0] ir,
                         input logic [31:0] a, input logic [31:0] b);
        of_valid = v;
        of_pc    = pc;
        of_ir    = ir;
        of_rf_a  = a;
        of_rf_b  = b;
    endtask

    // One clock: check stall, predict EX contents, push, clock, pop and compare
    task automatic step();
        ex_t nx, e;
        ex_t bub;
        logic [31:0] fa, fb;
        bit lu, stall;
        #1;
        lu    = m_lu();
        stall = !bt && (hold || lu);
        if (!reset) check("stall", {31'd0, of_stall}, {31'd0, stall});
        bub = '{v: 1'b0, pc: 32'd0, ir: 32'h6800_0000, a: 32'd0, b: 32'd0, op2: 32'd0};
        fa  = c1 ? rw_result : of_rf_a;
        fb  = c2 ? rw_result : of_rf_b;
        if (reset || bt)   nx = bub;
        else if (hold)     nx = mdl;
        else if (lu)       nx = bub;
        else nx = '{v: of_valid, pc: of_pc, ir: of_ir, a: fa, b: fb,
                    op2: of_ir[26] ? m_imm(of_ir) : fb};
`ifdef OF_EX_PERF_EN
        if (reset) begin
            pb = 0; pf1 = 0; pf2 = 0;
        end else if (bt) pb++;
        else if (!hold) begin
            if (lu) pb++;
            else begin
                if (c1) pf1++;
                if (c2) pf2++;
            end
        end
`endif
        q.push_back(nx);
        mdl = nx;
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
        check("ex_pc",  ex_pc,  e.pc);
        check("ex_ir",  ex_ir,  e.ir);
        check("ex_a",   ex_a,   e.a);
        check("ex_b",   ex_b,   e.b);
        check("ex_op2", ex_op2, e.op2);
`ifdef OF_EX_PERF_EN
        check("perf_bub", perf_bubbles,  pb);
        check("perf_f1",  perf_fwd_src1, pf1);
        check("perf_f2",  perf_fwd_src2, pf2);
`endif
    endtask

    initial begin
        logic [31:0] add_ir;
        logic [31:0] held_ir;
        logic [31:0] last_ir;
        logic [1:0]  md;

        reset = 1'b1;
        setof(1'b0, 32'd0, 32'h6800_0000, 32'd0, 32'd0);
        rw_result = 32'd0;
        c1 = 1'b0; c2 = 1'b0; bt = 1'b0; hold = 1'b0;
        mdl = '{v: 1'b0, pc: 32'd0, ir: 32'h6800_0000, a: 32'd0, b: 32'd0, op2: 32'd0};
`ifdef OF_EX_PERF_EN
        pb = 0; pf1 = 0; pf2 = 0;
`endif

        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_ir",    ex_ir,  32'h6800_0000);
        check("rst_a",     ex_a,   32'd0);
        check("rst_b",     ex_b,   32'd0);
        check("rst_op2",   ex_op2, 32'd0);
        check("rst_stall", {31'd0, of_stall}, 32'd0);

        // add r3,r1,r2 with src2 forwarded
        setof(1'b1, 32'h100, ins(0, 1'b0, 3, 1, rs2f(2)), 32'h7, 32'h5);
        rw_result = 32'h1234;
        c2 = 1'b1;
        step();
        check("fwd_b",   ex_b,   32'h1234);
        check("fwd_op2", ex_op2, 32'h1234);
        check("fwd_a",   ex_a,   32'h7);
        c2 = 1'b0;

        // addi with the three extension modes
        for (int m = 0; m < 3; m++) begin
            md = 2'(m);
            setof(1'b1, 32'h104, ins(0, 1'b1, 1, 2, {md, 16'hFFFF}), 32'h1, 32'h2);
            step();
            case (m)
                0: check("imm_sx", ex_op2, 32'hFFFF_FFFF);
                1: check("imm_zx", ex_op2, 32'h0000_FFFF);
                default: check("imm_hi", ex_op2, 32'hFFFF_0000);
            endcase
        end

        // load-use: ld r4 then add r5,r4,r1
`ifdef OF_EX_PERF_EN
        pb = 0;
        reset = 1'b1; step(); reset = 1'b0;
`endif
        setof(1'b1, 32'h200, ins(14, 1'b1, 4, 1, 18'h00010), 32'h40, 32'h0);
        step();
        add_ir = ins(0, 1'b0, 5, 4, rs2f(1));
        setof(1'b1, 32'h204, add_ir, 32'h11, 32'h22);
        #1;
        check("lu_stall", {31'd0, of_stall}, 32'd1);
        step();
        check("lu_bub_v",  {31'd0, ex_valid}, 32'd0);
        check("lu_bub_ir", ex_ir, 32'h6800_0000);
        #1;
        check("lu_stall_end", {31'd0, of_stall}, 32'd0);
        step();
        check("lu_add_ir", ex_ir, add_ir);
        check("lu_add_v",  {31'd0, ex_valid}, 32'd1);
`ifdef OF_EX_PERF_EN
        check("lu_perf", perf_bubbles, 32'd1);
`endif

        // load-use coinciding with a flush
        setof(1'b1, 32'h300, ins(14, 1'b1, 4, 1, 18'h00010), 32'h40, 32'h0);
        step();
        setof(1'b1, 32'h304, add_ir, 32'h11, 32'h22);
        bt = 1'b1;
        #1;
        check("bt_stall", {31'd0, of_stall}, 32'd0);
        step();
        check("bt_bub_v", {31'd0, ex_valid}, 32'd0);
        bt = 1'b0;

        // hold for 3 cycles with OF changing
        held_ir = ins(1, 1'b0, 3, 6, rs2f(7));
        setof(1'b1, 32'h400, held_ir, 32'h9, 32'h8);
        step();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            last_ir = ins(0, 1'b0, 2 + k, 1, rs2f(2));
            setof(1'b1, 32'h500 + 32'(4 * k), last_ir, 32'(k), 32'(k + 1));
            #1;
            check("hold_stall", {31'd0, of_stall}, 32'd1);
            step();
            check("hold_ir", ex_ir, held_ir);
        end
        hold = 1'b0;
        step();
        check("hold_rel_ir", ex_ir, last_ir);

        // reset in the middle of a hold
        hold = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        hold  = 1'b0;
        #1;
        check("rst_hold_stall", {31'd0, of_stall}, 32'd0);
        check("rst_hold_ir",    ex_ir, 32'h6800_0000);

        // constrained-random traffic checked against the model
        for (int n = 0; n < 400; n++) begin
            setof($urandom_range(0, 9) != 0, $urandom,
                  ins($urandom_range(0, 20), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 5), $urandom_range(0, 5),
                      18'($urandom)),
                  $urandom, $urandom);
            if ($urandom_range(0, 3) == 0)
                of_ir[31:27] = 5'd14;
            rw_result = $urandom;
            c1    = 1'($urandom_range(0, 1));
            c2    = 1'($urandom_range(0, 1));
            bt    = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 6) == 0);
            reset = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
